// File: rtl/bcd_timekeeper.sv
// -----------------------------------------------------------------------------
// bcd_timekeeper
//
// Purpose:
//   Generates hh:mm:ss as BCD digits for the VGA clock display. A seconds
//   prescaler divides the pixel clock down to 1 Hz. Cascaded BCD counters
//   handle seconds, minutes and hours. One-cycle adjust pulses step each field.
//   The minute-change strobe feeds the renderer's colour offset.
//
// Configuration:
//   TIMEKEEPER_12H_EN  defined   -> 12-hour mode (12,01..11,12) with pm flag;
//                                   reset time is 12:00:00, pm=0.
//                      undefined -> 24-hour mode (00..23); pm tied 0.
//
// Parameters:
//   CLK_HZ   pixel-clock cycles per second (>= 2)
//
// Ports:
//   clk       in   pixel clock, rising-edge active
//   reset_n   in   asynchronous active-low reset
//   adj_sec   in   increment seconds field (one step per cycle while high)
//   adj_min   in   increment minutes field
//   adj_hrs   in   increment hours field
//   sec_u/sec_d, min_u/min_d, hrs_u/hrs_d  out  BCD digits
//   pm        out  afternoon flag (12-hour mode only, else 0)
//   sec_tick  out  one-cycle strobe, coincident with the new seconds value
//   min_tick  out  one-cycle strobe, coincident with a new minutes value
//
// Every output comes straight from a flop.
// -----------------------------------------------------------------------------
module bcd_timekeeper #(
  parameter int unsigned CLK_HZ = 31_500_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       adj_sec,
  input  logic       adj_min,
  input  logic       adj_hrs,
  output logic [3:0] sec_u,
  output logic [2:0] sec_d,
  output logic [3:0] min_u,
  output logic [2:0] min_d,
  output logic [3:0] hrs_u,
  output logic [1:0] hrs_d,
  output logic       pm,
  output logic       sec_tick,
  output logic       min_tick
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);

`ifdef TIMEKEEPER_12H_EN
  localparam logic [1:0] HRS_D_RST = 2'd1;
  localparam logic [3:0] HRS_U_RST = 4'd2;
`else
  localparam logic [1:0] HRS_D_RST = 2'd0;
  localparam logic [3:0] HRS_U_RST = 4'd0;
`endif

  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    sec_u_q, sec_u_d;
  logic [2:0]    sec_d_q, sec_d_d;
  logic [3:0]    min_u_q, min_u_d;
  logic [2:0]    min_d_q, min_d_d;
  logic [3:0]    hrs_u_q, hrs_u_d;
  logic [1:0]    hrs_d_q, hrs_d_d;
  logic          sec_tick_q, min_tick_q;
`ifdef TIMEKEEPER_12H_EN
  logic          pm_q, pm_d;
`endif

  logic expire;
  logic inc_s, inc_m, inc_h;
  logic carry_s, carry_m;
  logic sec_at_59, min_at_59;

  // Carries only propagate from the prescaler path: an adjust pulse at 59
  // wraps its own field and leaves the next field alone.
  always_comb begin
    expire    = (pre_q == PRE_LAST);
    pre_d     = expire ? '0 : pre_q + 1'b1;

    sec_at_59 = (sec_d_q == 3'd5) && (sec_u_q == 4'd9);
    min_at_59 = (min_d_q == 3'd5) && (min_u_q == 4'd9);

    // Coincident sources are ORed so each field advances at most once a cycle.
    inc_s     = expire | adj_sec;
    carry_s   = expire & sec_at_59;
    inc_m     = carry_s | adj_min;
    carry_m   = carry_s & min_at_59;
    inc_h     = carry_m | adj_hrs;

    sec_u_d = sec_u_q;
    sec_d_d = sec_d_q;
    min_u_d = min_u_q;
    min_d_d = min_d_q;
    hrs_u_d = hrs_u_q;
    hrs_d_d = hrs_d_q;
`ifdef TIMEKEEPER_12H_EN
    pm_d    = pm_q;
`endif

    if (inc_s) begin
      if (sec_u_q == 4'd9) begin
        sec_u_d = 4'd0;
        sec_d_d = (sec_d_q == 3'd5) ? 3'd0 : sec_d_q + 3'd1;
      end else begin
        sec_u_d = sec_u_q + 4'd1;
      end
    end

    if (inc_m) begin
      if (min_u_q == 4'd9) begin
        min_u_d = 4'd0;
        min_d_d = (min_d_q == 3'd5) ? 3'd0 : min_d_q + 3'd1;
      end else begin
        min_u_d = min_u_q + 4'd1;
      end
    end

    if (inc_h) begin
`ifdef TIMEKEEPER_12H_EN
      if (hrs_d_q == 2'd1 && hrs_u_q == 4'd2) begin
        // 12 -> 01 keeps the meridiem
        hrs_d_d = 2'd0;
        hrs_u_d = 4'd1;
      end else if (hrs_d_q == 2'd1 && hrs_u_q == 4'd1) begin
        // 11 -> 12 crosses noon/midnight
        hrs_d_d = 2'd1;
        hrs_u_d = 4'd2;
        pm_d    = ~pm_q;
      end else if (hrs_u_q == 4'd9) begin
        hrs_d_d = 2'd1;
        hrs_u_d = 4'd0;
      end else begin
        hrs_u_d = hrs_u_q + 4'd1;
      end
`else
      if (hrs_d_q == 2'd2 && hrs_u_q == 4'd3) begin
        hrs_d_d = 2'd0;
        hrs_u_d = 4'd0;
      end else if (hrs_u_q == 4'd9) begin
        hrs_d_d = hrs_d_q + 2'd1;
        hrs_u_d = 4'd0;
      end else begin
        hrs_u_d = hrs_u_q + 4'd1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q      <= '0;
      sec_u_q    <= 4'd0;
      sec_d_q    <= 3'd0;
      min_u_q    <= 4'd0;
      min_d_q    <= 3'd0;
      hrs_u_q    <= HRS_U_RST;
      hrs_d_q    <= HRS_D_RST;
      sec_tick_q <= 1'b0;
      min_tick_q <= 1'b0;
`ifdef TIMEKEEPER_12H_EN
      pm_q       <= 1'b0;
`endif
    end else begin
      pre_q      <= pre_d;
      sec_u_q    <= sec_u_d;
      sec_d_q    <= sec_d_d;
      min_u_q    <= min_u_d;
      min_d_q    <= min_d_d;
      hrs_u_q    <= hrs_u_d;
      hrs_d_q    <= hrs_d_d;
      sec_tick_q <= expire;
      // Every minutes increment changes the value, so the strobe is inc_m.
      min_tick_q <= inc_m;
`ifdef TIMEKEEPER_12H_EN
      pm_q       <= pm_d;
`endif
    end
  end

  assign sec_u    = sec_u_q;
  assign sec_d    = sec_d_q;
  assign min_u    = min_u_q;
  assign min_d    = min_d_q;
  assign hrs_u    = hrs_u_q;
  assign hrs_d    = hrs_d_q;
  assign sec_tick = sec_tick_q;
  assign min_tick = min_tick_q;
`ifdef TIMEKEEPER_12H_EN
  assign pm       = pm_q;
`else
  assign pm       = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_timekeeper.sv
// -----------------------------------------------------------------------------
// tb_bcd_timekeeper
//
// Directed bench for bcd_timekeeper with CLK_HZ=4. Time values are packed one
// BCD digit per nibble (0x00hhmmss) so mismatches read directly as hh:mm:ss.
// Inputs change and outputs are sampled 1 ns after each rising edge; with a
// reset release at that same point, prescaler expiries land on edges 4, 8, 12...
// -----------------------------------------------------------------------------
module tb_bcd_timekeeper;

  localparam int unsigned CLK_HZ = 4;
`ifdef TIMEKEEPER_12H_EN
  localparam int HR0 = 12;
`else
  localparam int HR0 = 0;
`endif

  logic       clk;
  logic       reset_n;
  logic       adj_sec, adj_min, adj_hrs;
  logic [3:0] sec_u;
  logic [2:0] sec_d;
  logic [3:0] min_u;
  logic [2:0] min_d;
  logic [3:0] hrs_u;
  logic [1:0] hrs_d;
  logic       pm, sec_tick, min_tick;

  int total;
  int bad;
  logic [31:0] exp_q[$];

  bcd_timekeeper #(.CLK_HZ(CLK_HZ)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .adj_sec  (adj_sec),
    .adj_min  (adj_min),
    .adj_hrs  (adj_hrs),
    .sec_u    (sec_u),
    .sec_d    (sec_d),
    .min_u    (min_u),
    .min_d    (min_d),
    .hrs_u    (hrs_u),
    .hrs_d    (hrs_d),
    .pm       (pm),
    .sec_tick (sec_tick),
    .min_tick (min_tick)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [31:0] tm(input int h, input int m, input int s);
    logic [31:0] v;
    v = {8'h00, 4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
         4'(s / 10), 4'(s % 10)};
    return v;
  endfunction

  function automatic logic [31:0] obs_tm();
    return {8'h00, 2'b00, hrs_d, hrs_u, 1'b0, min_d, min_u, 1'b0, sec_d, sec_u};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock edge with the given adjust levels applied, then sample point.
  task automatic step(input logic h, input logic m, input logic s);
    adj_hrs = h;
    adj_min = m;
    adj_sec = s;
    @(posedge clk);
    #1;
    adj_hrs = 1'b0;
    adj_min = 1'b0;
    adj_sec = 1'b0;
  endtask

  task automatic hold(input logic h, input logic m, input logic s, input int n);
    for (int i = 0; i < n; i++) step(h, m, s);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    adj_hrs = 1'b0;
    adj_min = 1'b0;
    adj_sec = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    adj_hrs = 1'b0;
    adj_min = 1'b0;
    adj_sec = 1'b0;

    // Reset state and first tick timing.
    do_reset();
    check("rst_time", obs_tm(), tm(HR0, 0, 0));
    check("rst_pm", 32'(pm), 32'd0);
    check("rst_stick", 32'(sec_tick), 32'd0);
    check("rst_mtick", 32'(min_tick), 32'd0);
    hold(1'b0, 1'b0, 1'b0, 3);
    check("pre_tick_e3", 32'(sec_tick), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    check("first_tick", 32'(sec_tick), 32'd1);
    check("first_sec", obs_tm(), tm(HR0, 0, 1));
    check("first_mtick", 32'(min_tick), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    check("tick_width", 32'(sec_tick), 32'd0);

    // 00:00:59 -> 00:01:00 by prescaler carry.
    do_reset();
    hold(1'b0, 1'b0, 1'b1, 59);
    exp_q.push_back(tm(HR0, 0, 59));
    exp_q.push_back(tm(HR0, 1, 0));
    check("pre_59", obs_tm(), exp_q.pop_front());
    step(1'b0, 1'b0, 1'b0);
    check("carry_min", obs_tm(), exp_q.pop_front());
    check("carry_mtick", 32'(min_tick), 32'd1);
    check("carry_stick", 32'(sec_tick), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    check("mtick_width", 32'(min_tick), 32'd0);

`ifndef TIMEKEEPER_12H_EN
    // 23:59:59 -> 00:00:00 in one cycle.
    do_reset();
    hold(1'b1, 1'b1, 1'b1, 23);
    hold(1'b0, 1'b1, 1'b1, 36);
    exp_q.push_back(tm(23, 59, 59));
    exp_q.push_back(tm(0, 0, 0));
    check("pre_day", obs_tm(), exp_q.pop_front());
    step(1'b0, 1'b0, 1'b0);
    check("day_wrap", obs_tm(), exp_q.pop_front());
    check("day_mtick", 32'(min_tick), 32'd1);
`endif

    // adj_sec at 59 wraps with no carry (edge 62 is not an expiry).
    do_reset();
    hold(1'b0, 1'b0, 1'b0, 2);
    hold(1'b0, 1'b0, 1'b1, 59);
    check("adjs_pre", obs_tm(), tm(HR0, 0, 59));
    step(1'b0, 1'b0, 1'b1);
    check("adjs_wrap", obs_tm(), tm(HR0, 0, 0));
    check("adjs_no_mtick", 32'(min_tick), 32'd0);

    // adj_sec coincident with expiry at 30 gives 31.
    do_reset();
    hold(1'b0, 1'b0, 1'b1, 30);
    step(1'b0, 1'b0, 1'b0);
    check("s30_pre", obs_tm(), tm(HR0, 0, 30));
    step(1'b0, 1'b0, 1'b1);
    check("s30_merge", obs_tm(), tm(HR0, 0, 31));

    // adj_min coincident with seconds carry at 00:05:59.
    do_reset();
    hold(1'b0, 1'b1, 1'b1, 5);
    hold(1'b0, 1'b0, 1'b1, 54);
    check("m5_pre", obs_tm(), tm(HR0, 5, 59));
    step(1'b0, 1'b1, 1'b0);
    check("m5_merge", obs_tm(), tm(HR0, 6, 0));
    check("m5_mtick", 32'(min_tick), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    check("m5_mtick_off", 32'(min_tick), 32'd0);
    check("m5_hold", obs_tm(), tm(HR0, 6, 0));

    // adj_min at 59 wraps, hours unchanged.
    do_reset();
    hold(1'b0, 1'b1, 1'b0, 59);
    check("m59_pre", obs_tm(), tm(HR0, 59, 14));
    step(1'b0, 1'b1, 1'b0);
    check("m59_wrap", obs_tm(), tm(HR0, 0, 15));
    check("m59_mtick", 32'(min_tick), 32'd1);

    // Asynchronous reset mid-count, no clock edge.
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst", obs_tm(), tm(HR0, 0, 0));
    check("async_mtick", 32'(min_tick), 32'd0);
    check("async_stick", 32'(sec_tick), 32'd0);

`ifdef TIMEKEEPER_12H_EN
    // 12-hour: 11:59:59 -> 12:00:00 pm, then adj_hrs -> 01 pm.
    do_reset();
    check("h12_rst", obs_tm(), tm(12, 0, 0));
    check("h12_rst_pm", 32'(pm), 32'd0);
    hold(1'b1, 1'b1, 1'b1, 59);
    check("h12_pre", obs_tm(), tm(11, 59, 59));
    check("h12_pre_pm", 32'(pm), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    check("h12_noon", obs_tm(), tm(12, 0, 0));
    check("h12_noon_pm", 32'(pm), 32'd1);
    step(1'b1, 1'b0, 1'b0);
    check("h12_one", obs_tm(), tm(1, 0, 0));
    check("h12_one_pm", 32'(pm), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("h12_async", obs_tm(), tm(12, 0, 0));
    check("h12_async_pm", 32'(pm), 32'd0);
`endif

    // ---------------- final report ----------------
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
